// File: rtl/dmul_rot_lfsr_param.sv
// dmul_rot_lfsr_param
//   Deterministic stochastic-computing multiplier. Operand A is compared
//   against a full-period (zero-extended) Fibonacci LFSR. Operand B's LFSR
//   steps once per A period, so a run of 2^(2N) cycles gives the exact
//   product count. Truncated runs of 2^iLog2Len cycles give progressive
//   precision.
//
//   Optional feature macro: DMUL_BIPOLAR_EN
//     defined   -> iMode selects unipolar AND (0) or bipolar XNOR (1)
//     undefined -> unipolar only; iMode is kept on the pin list but unused
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   iA, iB    unsigned operands (INWD bits)
//   load      capture iA/iB (ignored while running)
//   start     begin a run (ignored while running)
//   iLog2Len  run length exponent, clamped to 2*INWD
//   iMode     0 = unipolar, 1 = bipolar (only with DMUL_BIPOLAR_EN)
//   busy      run in progress
//   done      one-cycle pulse, oC final
//   oC        running / final ones count (2*INWD bits, saturating)
module dmul_rot_lfsr_param #(
  parameter int              INWD   = 8,
  parameter logic [INWD-1:0] SEED_A = {{(INWD-1){1'b0}}, 1'b1},
  parameter logic [INWD-1:0] SEED_B = {{(INWD-1){1'b0}}, 1'b1},
  parameter int              LW     = $clog2(2*INWD+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INWD-1:0]   iA,
  input  logic [INWD-1:0]   iB,
  input  logic              load,
  input  logic              start,
  input  logic [LW-1:0]     iLog2Len,
  input  logic              iMode,
  output logic              busy,
  output logic              done,
  output logic [2*INWD-1:0] oC
);

  localparam int          OW    = 2*INWD;     // result width
  localparam int          CW    = 2*INWD + 1; // cycle counter width
  localparam logic [LW-1:0] MAXLG = LW'(2*INWD);

  // Maximal-length feedback taps (bit t-1 for tap t), widths 3..16.
  function automatic logic [15:0] tap_mask(input int n);
    case (n)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      default: return 16'hD008;
    endcase
  endfunction

  localparam logic [15:0]     TAPS16 = tap_mask(INWD);
  localparam logic [INWD-1:0] TAPS   = TAPS16[INWD-1:0];

  // Left-shifting Fibonacci LFSR. The extra term flips feedback when the
  // low N-1 bits are zero, splicing the all-zero state in between
  // 100..0 and 00..01 so the period becomes 2^N.
  function automatic logic [INWD-1:0] lfsr_next(input logic [INWD-1:0] s);
    logic fb;
    fb = (^(s & TAPS)) ^ (s[INWD-2:0] == '0);
    return {s[INWD-2:0], fb};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [INWD-1:0] r_regA, r_regB, r_rngA, r_rngB;
  logic [CW-1:0]   r_cnt;
  logic [LW-1:0]   r_lg;
  logic [OW-1:0]   r_c;

  logic            w_start_ok, w_load_ok, w_last;
  logic            w_bitA, w_bitB, w_prod;
  logic [INWD-1:0] w_rngA_nxt;
  logic [LW-1:0]   w_lg;
  logic [CW-1:0]   w_len_m1;

  assign w_start_ok = start && (r_state != S_RUN);
  assign w_load_ok  = load  && (r_state != S_RUN);
  assign w_lg       = (iLog2Len > MAXLG) ? MAXLG : iLog2Len;
  assign w_len_m1   = (CW'(1) << r_lg) - CW'(1);
  assign w_last     = (r_cnt == w_len_m1);
  assign w_rngA_nxt = lfsr_next(r_rngA);
  assign w_bitA     = (r_regA > r_rngA);
  assign w_bitB     = (r_regB > r_rngB);

`ifdef DMUL_BIPOLAR_EN
  logic r_mode;
  assign w_prod = r_mode ? ~(w_bitA ^ w_bitB) : (w_bitA & w_bitB);
`else
  logic w_unused_mode;
  assign w_unused_mode = iMode;
  assign w_prod        = w_bitA & w_bitB;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regA <= '0;
      r_regB <= '0;
      r_rngA <= '0;
      r_rngB <= '0;
      r_cnt  <= '0;
      r_lg   <= '0;
      r_c    <= '0;
`ifdef DMUL_BIPOLAR_EN
      r_mode <= 1'b0;
`endif
    end else begin
      if (w_load_ok) begin
        r_regA <= iA;
        r_regB <= iB;
      end
      if (w_start_ok) begin
        r_rngA <= SEED_A;
        r_rngB <= SEED_B;
        r_cnt  <= '0;
        r_c    <= '0;
        r_lg   <= w_lg;
`ifdef DMUL_BIPOLAR_EN
        r_mode <= iMode;
`endif
      end else if (r_state == S_RUN) begin
        r_rngA <= w_rngA_nxt;
        // B steps when A wraps back to its seed: one B value per A period
        if (w_rngA_nxt == SEED_A) r_rngB <= lfsr_next(r_rngB);
        r_cnt <= r_cnt + CW'(1);
        if (w_prod && !(&r_c)) r_c <= r_c + OW'(1);
      end
    end
  end

  assign oC = r_c;

endmodule

// File: tb/tb_dmul_rot_lfsr_param.sv
module tb_dmul_rot_lfsr_param;
  localparam int N    = 5;
  localparam int LW   = $clog2(2*N+1);
  localparam int SA   = 7;
  localparam int SB   = 9;
  localparam int FULL = 1 << (2*N);
  localparam int P    = 1 << N;

  logic           clk = 1'b0;
  logic           rst, load, start, iMode;
  logic [N-1:0]   iA, iB;
  logic [LW-1:0]  iLog2Len;
  logic           busy, done;
  logic [2*N-1:0] oC;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmul_rot_lfsr_param #(.INWD(N), .SEED_A(N'(SA)), .SEED_B(N'(SB))) dut (
    .clk(clk), .rst(rst), .iA(iA), .iB(iB), .load(load), .start(start),
    .iLog2Len(iLog2Len), .iMode(iMode), .busy(busy), .done(done), .oC(oC)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int eff_mode(input int m);
`ifdef DMUL_BIPOLAR_EN
    return m;
`else
    return 0 * m;
`endif
  endfunction

  function automatic int run_len(input int lg);
    return 1 << ((lg > 2*N) ? 2*N : lg);
  endfunction

  // Closed-form expectations; -1 where the result depends on the
  // particular LFSR ordering.
  function automatic int model(input int a, input int b, input int lg, input int m);
    int L, v, ba, bb;
    L = run_len(lg);
    if (L == FULL) begin
      v = (m != 0) ? a*b + (P-a)*(P-b) : a*b;
      return (v > FULL-1) ? FULL-1 : v;
    end
    if (L == P) begin
      bb = (b > SB);
      if (m != 0) return bb ? a : P - a;
      return bb ? a : 0;
    end
    if (L == 1) begin
      ba = (a > SA); bb = (b > SB);
      if (m != 0) return (ba == bb) ? 1 : 0;
      return ba & bb;
    end
    return -1;
  endfunction

  task automatic launch(input int a, input int b, input int lg, input int m);
    iA = N'(a); iB = N'(b); iLog2Len = LW'(lg); iMode = m[0];
    load = 1'b1; start = 1'b1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
  endtask

  // Counts busy cycles from the current negedge; leaves us in the done cycle.
  task automatic finish(input string tag, input int L, input int exp);
    int n = 0;
    while (busy && n < FULL + 8) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_len"}, n, L);
    chk({tag, "_done"}, int'(done), 1);
    if (exp >= 0) chk({tag, "_oC"}, int'(oC), exp);
    else          chk({tag, "_bound"}, int'(int'(oC) <= L), 1);
  endtask

  task automatic full_run(input string tag, input int a, input int b, input int lg, input int m);
    int hold;
    launch(a, b, lg, m);
    finish(tag, run_len(lg), model(a, b, lg, eff_mode(m)));
    hold = int'(oC);
    @(negedge clk);
    chk({tag, "_pulse"}, int'(done) + int'(busy), 0);
    @(negedge clk);
    chk({tag, "_hold"}, int'(oC), hold);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; iMode = 1'b0;
    iA = '0; iB = '0; iLog2Len = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_oC", int'(oC), 0);

    // directed corners
    full_run("mid", 16, 16, 2*N, 0);
    full_run("max", P-1, P-1, 2*N, 0);
    full_run("zeroA", 0, 20, 2*N, 0);
    full_run("clamp", 13, 22, 15, 0);
    full_run("trunc_hi", 16, 16, N, 0);
    full_run("trunc_lo", 16, 1, N, 0);
    full_run("one", 20, 30, 0, 0);
    full_run("bip_mid", 16, 16, 2*N, 1);
    full_run("bip_max", P-1, P-1, 2*N, 1);
    full_run("bip_sat", 0, 0, 2*N, 1);
    full_run("bip_trunc", 11, 3, N, 1);

    // start and load during RUN are ignored
    launch(21, 13, 2*N, 0);
    repeat (100) @(negedge clk);
    iA = N'(3); iB = N'(4); load = 1'b1; start = 1'b1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    finish("ignore", FULL - 101, 21*13);
    @(negedge clk);
    chk("ignore_once", int'(done) + int'(busy), 0);

    // start coincident with done: back-to-back runs
    launch(9, 27, 2*N, 0);
    finish("b2b1", FULL, 9*27);
    iA = N'(30); iB = N'(17); iLog2Len = LW'(2*N); iMode = 1'b0;
    load = 1'b1; start = 1'b1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    finish("b2b2", FULL, 30*17);
    @(negedge clk);

    // reset mid-run aborts
    launch(25, 25, 2*N, 0);
    repeat (999) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_oC", int'(oC), 0);
    full_run("after_abort", 25, 25, 2*N, 0);

    // randomized runs
    for (int k = 0; k < 14; k++) begin
      int a, b, lg, m;
      a  = int'($urandom_range(0, P-1));
      b  = int'($urandom_range(0, P-1));
      m  = int'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       lg = 2*N;
        1:       lg = N;
        2:       lg = int'($urandom_range(2*N, 15));
        default: lg = int'($urandom_range(0, 2*N));
      endcase
      full_run($sformatf("rnd%0d", k), a, b, lg, m);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
